acc_core: RTL and testbench

ACC_CORE -- requirements
Module: acc_core

---
 rtl/acc_core_pkg.sv | 27 ++
 rtl/acc_core_alu.sv | 31 +++
 rtl/acc_core.sv | 120 ++++++++++++
 tb/tb_acc_core.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/acc_core_pkg.sv
// rtl/acc_core_pkg.sv - opcode and state encodings for the accumulator core
package acc_core_pkg;

   localparam int OPCW = 4;

   typedef enum logic [OPCW-1:0] {
      OP_NOP  = 4'b0000,
      OP_LDI  = 4'b0001,
      OP_ST   = 4'b0011,
      OP_LD   = 4'b0100,
      OP_ADD  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_AND  = 4'b0111,
      OP_JMP  = 4'b1000,
      OP_JZ   = 4'b1001,
      OP_JC   = 4'b1010,
      OP_HALT = 4'b1111
   } opcode_t;

   typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

   // Opcodes whose EXECUTE cycle consumes rdata and therefore waits on ready.
   function automatic logic is_mem_op(input opcode_t op);
      return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
   endfunction

endpackage

// File: rtl/acc_core_alu.sv
// rtl/acc_core_alu.sv - combinational ALU: load/add/sub/and with carry (borrow on SUB) and zero
module acc_core_alu
   import acc_core_pkg::*;
#(
   parameter int DW = 8
) (
   input  opcode_t       op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          carry,
   output logic          zero
);

   always_comb begin
      result = b;
      carry  = 1'b0;
      case (op)
         OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND:  result = a & b;
         default: result = b;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/acc_core.sv
// rtl/acc_core.sv - multicycle accumulator CPU core (FETCH/DECODE/EXECUTE/HALT)
// Optional feature: define ACC_CORE_CARRY_EN to implement the C flag and JC.
module acc_core
   import acc_core_pkg::*;
#(
   parameter int DW        = 8,
   parameter int AW        = 8,
   parameter int DATA_BASE = 'hF0
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] rdata,
   input  logic          ready,
   output logic [DW-1:0] wdata,
   output logic          we,
   output logic [AW-1:0] mar,
   output logic [AW-1:0] pc,
   output logic [DW-1:0] ir,
   output logic [1:0]    flags,
   output logic          halted
);

   localparam int OPW = DW - OPCW;

   state_t        state;
   logic [DW-1:0] acc;
   logic          z_flag;
   logic          c_flag;

   opcode_t       op;
   logic [OPW-1:0] operand;
   logic [AW-1:0] target;
   logic [AW-1:0] fetch_daddr;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_result;
   logic          alu_carry;
   logic          alu_zero;

   assign op      = opcode_t'(ir[DW-1 -: OPCW]);
   assign operand = ir[OPW-1:0];
   assign target  = AW'(operand);
   // DECODE loads mar from the word arriving on rdata, before ir holds it.
   assign fetch_daddr = AW'(DATA_BASE) | AW'(rdata[OPW-1:0]);
   assign alu_b   = (op == OP_LDI) ? DW'(operand) : rdata;

   assign wdata = acc;
   assign flags = {c_flag, z_flag};

   acc_core_alu #(.DW(DW)) u_alu (
      .op     (op),
      .a      (acc),
      .b      (alu_b),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

`ifndef ACC_CORE_CARRY_EN
   logic unused_carry;
   assign unused_carry = alu_carry;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= FETCH;
         pc     <= '0;
         mar    <= '0;
         ir     <= '0;
         acc    <= '0;
         z_flag <= 1'b0;
         c_flag <= 1'b0;
         we     <= 1'b0;
         halted <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               mar   <= pc;
               pc    <= pc + 1'b1;
               we    <= 1'b0;
               state <= DECODE;
            end
            DECODE: begin
               if (ready) begin
                  ir    <= rdata;
                  mar   <= fetch_daddr;
                  state <= EXECUTE;
               end
            end
            EXECUTE: begin
               if (!is_mem_op(op) || ready) begin
                  state <= FETCH;
                  case (op)
                     OP_LDI, OP_LD, OP_ADD, OP_SUB, OP_AND: begin
                        acc    <= alu_result;
                        z_flag <= alu_zero;
`ifdef ACC_CORE_CARRY_EN
                        if (op == OP_ADD || op == OP_SUB)
                           c_flag <= alu_carry;
`endif
                     end
                     OP_ST:  we <= 1'b1;
                     OP_JMP: pc <= target;
                     OP_JZ:  if (z_flag) pc <= target;
`ifdef ACC_CORE_CARRY_EN
                     OP_JC:  if (c_flag) pc <= target;
`endif
                     OP_HALT: begin
                        state  <= HALT;
                        halted <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_core.sv
// tb/tb_acc_core.sv - directed self-checking bench for acc_core
module tb_acc_core;
   import acc_core_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] rdata, wdata, mar, pc, ir;
   logic       we, halted;
   logic [1:0] flags;
   logic [7:0] mem [0:255];
   int         n_cmp = 0;
   int         n_bad = 0;

`ifdef ACC_CORE_CARRY_EN
   localparam bit CARRY = 1'b1;
`else
   localparam bit CARRY = 1'b0;
`endif

   acc_core #(.DW(8), .AW(8), .DATA_BASE('hF0)) dut (
      .clock  (clock),
      .reset  (reset),
      .rdata  (rdata),
      .ready  (ready),
      .wdata  (wdata),
      .we     (we),
      .mar    (mar),
      .pc     (pc),
      .ir     (ir),
      .flags  (flags),
      .halted (halted)
   );

   always #5 clock = ~clock;
   assign rdata = mem[mar];
   always @(posedge clock) if (we) mem[mar] <= wdata;

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic start();
      reset = 1'b1;
      ready = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(2);
      n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc got=%h exp=00", pc); end
      n_cmp++; if (mar !== 8'h00) begin n_bad++; $display("FAIL reset_mar got=%h exp=00", mar); end
      n_cmp++; if (ir !== 8'h00) begin n_bad++; $display("FAIL reset_ir got=%h exp=00", ir); end
      n_cmp++; if (wdata !== 8'h00) begin n_bad++; $display("FAIL reset_acc got=%h exp=00", wdata); end
      n_cmp++; if (flags !== 2'b00) begin n_bad++; $display("FAIL reset_flags got=%b exp=00", flags); end
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b exp=0", we); end
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
   endtask

   // LDI 5; ADD [F1]=3; ST F2; HALT, then idle and reset out of HALT
   task automatic test_add_store_halt();
      clear_mem();
      mem[0] = 8'h15; mem[1] = 8'h51; mem[2] = 8'h32; mem[3] = 8'hF0; mem[8'hF1] = 8'h03;
      start();
      cyc(3);
      n_cmp++; if (wdata !== 8'h05) begin n_bad++; $display("FAIL ldi_acc got=%h exp=05", wdata); end
      cyc(3);
      n_cmp++; if (wdata !== 8'h08) begin n_bad++; $display("FAIL add_acc got=%h exp=08", wdata); end
      n_cmp++; if (flags !== 2'b00) begin n_bad++; $display("FAIL add_flags got=%b exp=00", flags); end
      cyc(3);
      n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL st_we got=%b exp=1", we); end
      n_cmp++; if (mar !== 8'hF2) begin n_bad++; $display("FAIL st_mar got=%h exp=f2", mar); end
      n_cmp++; if (wdata !== 8'h08) begin n_bad++; $display("FAIL st_wdata got=%h exp=08", wdata); end
      cyc(1);
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL st_we_pulse got=%b exp=0", we); end
      n_cmp++; if (mem[8'hF2] !== 8'h08) begin n_bad++; $display("FAIL st_mem got=%h exp=08", mem[8'hF2]); end
      cyc(2);
      n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
      n_cmp++; if (pc !== 8'h04) begin n_bad++; $display("FAIL halt_pc got=%h exp=04", pc); end
      cyc(10);
      n_cmp++; if (pc !== 8'h04) begin n_bad++; $display("FAIL halt_pc_frozen got=%h exp=04", pc); end
      n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_held got=%b exp=1", halted); end
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL halt_we got=%b exp=0", we); end
      reset = 1'b1;
      #1;
      n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL halt_reset_pc got=%h exp=00", pc); end
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_reset_halted got=%b exp=0", halted); end
      n_cmp++; if (dut.state !== FETCH) begin n_bad++; $display("FAIL halt_reset_state got=%0d exp=%0d", dut.state, FETCH); end
      cyc(1);
   endtask

   // LDI 0; SUB [F0]=1; JC 10
   task automatic test_sub_borrow();
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h60; mem[2] = 8'hAA; mem[8'hF0] = 8'h01;
      start();
      cyc(6);
      n_cmp++; if (wdata !== 8'hFF) begin n_bad++; $display("FAIL sub_acc got=%h exp=ff", wdata); end
      n_cmp++; if (flags !== {CARRY, 1'b0}) begin n_bad++; $display("FAIL sub_flags got=%b exp=%b", flags, {CARRY, 1'b0}); end
      cyc(3);
      n_cmp++; if (pc !== (CARRY ? 8'h0A : 8'h03)) begin n_bad++; $display("FAIL jc_pc got=%h exp=%h", pc, CARRY ? 8'h0A : 8'h03); end
   endtask

   // LDI 0; JZ 5 (taken); @5 LDI 1; JZ 2 (not taken); JMP 12
   task automatic test_jumps();
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h95; mem[5] = 8'h11; mem[6] = 8'h92; mem[7] = 8'h8C;
      start();
      cyc(6);
      n_cmp++; if (pc !== 8'h05) begin n_bad++; $display("FAIL jz_taken_pc got=%h exp=05", pc); end
      n_cmp++; if (flags[0] !== 1'b1) begin n_bad++; $display("FAIL jz_taken_z got=%b exp=1", flags[0]); end
      cyc(6);
      n_cmp++; if (pc !== 8'h07) begin n_bad++; $display("FAIL jz_not_taken_pc got=%h exp=07", pc); end
      n_cmp++; if (flags[0] !== 1'b0) begin n_bad++; $display("FAIL jz_not_taken_z got=%b exp=0", flags[0]); end
      cyc(3);
      n_cmp++; if (pc !== 8'h0C) begin n_bad++; $display("FAIL jmp_pc got=%h exp=0c", pc); end
   endtask

   // LDI 2; ADD [F3]=7 with ready low for 4 EXECUTE cycles
   task automatic test_wait_states();
      clear_mem();
      mem[0] = 8'h12; mem[1] = 8'h53; mem[8'hF3] = 8'h07;
      start();
      cyc(5);
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         n_cmp++; if (wdata !== 8'h02) begin n_bad++; $display("FAIL wait_acc_hold%0d got=%h exp=02", i, wdata); end
      end
      ready = 1'b1;
      cyc(1);
      n_cmp++; if (wdata !== 8'h09) begin n_bad++; $display("FAIL wait_acc_done got=%h exp=09", wdata); end
      n_cmp++; if (dut.state !== FETCH) begin n_bad++; $display("FAIL wait_state_done got=%0d exp=%0d", dut.state, FETCH); end
      cyc(3);
      n_cmp++; if (wdata !== 8'h09) begin n_bad++; $display("FAIL wait_acc_once got=%h exp=09", wdata); end
   endtask

   // LD [F4]=FF; ADD [F5]=1; JC 4
   task automatic test_add_overflow();
      clear_mem();
      mem[0] = 8'h44; mem[1] = 8'h55; mem[2] = 8'hA4; mem[8'hF4] = 8'hFF; mem[8'hF5] = 8'h01;
      start();
      cyc(6);
      n_cmp++; if (wdata !== 8'h00) begin n_bad++; $display("FAIL ovf_acc got=%h exp=00", wdata); end
      n_cmp++; if (flags !== {CARRY, 1'b1}) begin n_bad++; $display("FAIL ovf_flags got=%b exp=%b", flags, {CARRY, 1'b1}); end
      cyc(3);
      n_cmp++; if (pc !== (CARRY ? 8'h04 : 8'h03)) begin n_bad++; $display("FAIL ovf_jc_pc got=%h exp=%h", pc, CARRY ? 8'h04 : 8'h03); end
   endtask

   // ST F5 interrupted by reset while in EXECUTE
   task automatic test_reset_abort();
      clear_mem();
      mem[0] = 8'h35; mem[8'hF5] = 8'hAA;
      start();
      cyc(2);
      reset = 1'b1;
      #1;
      n_cmp++; if (dut.state !== FETCH) begin n_bad++; $display("FAIL abort_state got=%0d exp=%0d", dut.state, FETCH); end
      cyc(2);
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL abort_we got=%b exp=0", we); end
      n_cmp++; if (mem[8'hF5] !== 8'hAA) begin n_bad++; $display("FAIL abort_mem got=%h exp=aa", mem[8'hF5]); end
   endtask

   // 255 NOPs bring pc to FF; the next FETCH wraps it
   task automatic test_pc_wrap();
      clear_mem();
      start();
      cyc(765);
      n_cmp++; if (pc !== 8'hFF) begin n_bad++; $display("FAIL wrap_pc_pre got=%h exp=ff", pc); end
      cyc(1);
      n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL wrap_pc got=%h exp=00", pc); end
      n_cmp++; if (mar !== 8'hFF) begin n_bad++; $display("FAIL wrap_mar got=%h exp=ff", mar); end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_add_store_halt();
      test_sub_borrow();
      test_jumps();
      test_wait_states();
      test_add_overflow();
      test_reset_abort();
      test_pc_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
